snes_bus_sync: RTL and testbench

Front-end conditioner between the raw SNES cartridge-edge signals and the cheat/hook engine. It synchronises and deglitches the asynchronous SNES control lines and turns their edges into single-cycle strobes: `SNES_rd_strobe`, `SNES_wr_strobe`, `SNES_cycle_start` and `SNES_reset_strobe`. It also presents the A-bus address, B-bus address and write data as stable registered values aligned to those strobes. All downstream address matching, push-pattern detection and command decoding consume its outputs directly.

---
 rtl/snes_bus_sync_if.sv | 48 ++++
 rtl/snes_bus_sync.sv | 136 +++++++++++++
 tb/tb_snes_bus_sync.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_bus_sync_if.sv
// snes_bus_sync_if
//   Bundle of the raw SNES cartridge-edge inputs and the conditioned
//   strobes / registered bus values produced by snes_bus_sync.
//   master : the SNES side (drives raw lines, observes conditioned outputs)
//   slave  : the conditioner (samples raw lines, drives conditioned outputs)
//
//   Raw inputs : SNES_READ_IN, SNES_WRITE_IN, SNES_CPU_CLK_IN, SNES_RESET_IN
//                (all asynchronous), SNES_ADDR_IN[23:0], SNES_PA_IN[7:0],
//                SNES_DATA_IN[7:0]
//   Outputs    : SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start,
//                SNES_reset_strobe (one-cycle pulses), snes_in_reset (level),
//                SNES_ADDR[23:0], SNES_PA[7:0], SNES_DATA[7:0] (registered)
//
//   Strobe semantics: every strobe is high for exactly one clk cycle per
//   accepted edge; the bus outputs are valid in that same cycle and hold
//   until the next capture. There is no back-pressure (no ready).
interface snes_bus_sync_if;
   logic        SNES_READ_IN;
   logic        SNES_WRITE_IN;
   logic        SNES_CPU_CLK_IN;
   logic        SNES_RESET_IN;
   logic [23:0] SNES_ADDR_IN;
   logic [7:0]  SNES_PA_IN;
   logic [7:0]  SNES_DATA_IN;

   logic        SNES_rd_strobe;
   logic        SNES_wr_strobe;
   logic        SNES_cycle_start;
   logic        SNES_reset_strobe;
   logic        snes_in_reset;
   logic [23:0] SNES_ADDR;
   logic [7:0]  SNES_PA;
   logic [7:0]  SNES_DATA;

   modport master (
      output SNES_READ_IN, SNES_WRITE_IN, SNES_CPU_CLK_IN, SNES_RESET_IN,
             SNES_ADDR_IN, SNES_PA_IN, SNES_DATA_IN,
      input  SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start,
             SNES_reset_strobe, snes_in_reset, SNES_ADDR, SNES_PA, SNES_DATA
   );

   modport slave (
      input  SNES_READ_IN, SNES_WRITE_IN, SNES_CPU_CLK_IN, SNES_RESET_IN,
             SNES_ADDR_IN, SNES_PA_IN, SNES_DATA_IN,
      output SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start,
             SNES_reset_strobe, snes_in_reset, SNES_ADDR, SNES_PA, SNES_DATA
   );
endinterface

// File: rtl/snes_bus_sync.sv
// snes_bus_sync
//   Synchronises and deglitches the asynchronous SNES control lines and
//   turns accepted edges into single-cycle strobes, with the A-bus address,
//   B-bus address and write data registered and aligned to those strobes.
//
//   Parameter FILTER (1..15): consecutive synchronised samples at a new
//   level needed before an edge is accepted.
//
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : snes_bus_sync_if.slave (raw inputs in, conditioned outputs out)
module snes_bus_sync #(
   parameter int FILTER = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   snes_bus_sync_if.slave  bus
);

   localparam int            CW   = $clog2(FILTER + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

   // Control line index: 0 = /RD, 1 = /WR, 2 = CPU clock, 3 = /RESET
   logic [3:0]    raw;
   logic [3:0]    s1, s2, lvl, fire;
   logic [CW-1:0] cnt [4];

   logic [23:0]   p1_addr, p2_addr;
   logic [7:0]    p1_pa, p2_pa, p1_data, p2_data;

   logic          rdf, wrr, wrf, ckr, rsr, in_reset;

   logic          rd_q, wr_q, ck_q, rs_q;
   logic [23:0]   addr_q;
   logic [7:0]    pa_q, data_q;

   assign raw = {bus.SNES_RESET_IN, bus.SNES_CPU_CLK_IN,
                 bus.SNES_WRITE_IN, bus.SNES_READ_IN};

   // Control synchronisers and bus pipe share the same two-stage latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= '0;
         s2      <= '0;
         p1_addr <= '0;
         p2_addr <= '0;
         p1_pa   <= '0;
         p2_pa   <= '0;
         p1_data <= '0;
         p2_data <= '0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         p1_addr <= bus.SNES_ADDR_IN;
         p2_addr <= p1_addr;
         p1_pa   <= bus.SNES_PA_IN;
         p2_pa   <= p1_pa;
         p1_data <= bus.SNES_DATA_IN;
         p2_data <= p1_data;
      end
   end

   // An edge fires when s2 has disagreed with the filtered level for
   // FILTER consecutive samples (this one included).
   always_comb begin
      fire = '0;
      for (int i = 0; i < 4; i++) begin
         fire[i] = (s2[i] != lvl[i]) && (cnt[i] == LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (fire[i]) begin
               lvl[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Edge direction is taken from the level before it flips
   assign rdf      = fire[0] &  lvl[0];
   assign wrr      = fire[1] & ~lvl[1];
   assign wrf      = fire[1] &  lvl[1];
   assign ckr      = fire[2] & ~lvl[2];
   assign rsr      = fire[3] & ~lvl[3];
   assign in_reset = ~lvl[3];

   // in_reset is the pre-edge value, so a strobe coinciding with the
   // /RESET release edge is still masked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         ck_q   <= 1'b0;
         rs_q   <= 1'b0;
         addr_q <= '0;
         pa_q   <= '0;
         data_q <= '0;
      end else begin
         rd_q <= rdf & ~in_reset;
         wr_q <= wrr & ~in_reset;
         ck_q <= ckr & ~in_reset;
         rs_q <= rsr;
         if (!in_reset && (rdf || wrf || ckr)) begin
            addr_q <= p2_addr;
            pa_q   <= p2_pa;
         end
         if (!in_reset && wrr) begin
            data_q <= p2_data;
         end
      end
   end

   assign bus.SNES_rd_strobe    = rd_q;
   assign bus.SNES_wr_strobe    = wr_q;
   assign bus.SNES_cycle_start  = ck_q;
   assign bus.SNES_reset_strobe = rs_q;
   assign bus.snes_in_reset     = in_reset;
   assign bus.SNES_ADDR         = addr_q;
   assign bus.SNES_PA           = pa_q;
   assign bus.SNES_DATA         = data_q;

endmodule

// File: tb/tb_snes_bus_sync.sv
// tb_snes_bus_sync
//   Directed scenarios followed by a randomized phase. A reference model
//   keeps the history of raw samples and accepts a new level when the last
//   FILTER synchronised samples all disagree with the current level.
module tb_snes_bus_sync;

   localparam int FILTER = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   snes_bus_sync_if bus_if ();

   snes_bus_sync #(.FILTER(FILTER)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_err    = 0;

   logic [3:0]  ctl_q [$];   // raw control samples, one per clock edge
   logic [39:0] bus_q [$];   // raw {addr, pa, data}, one per clock edge
   logic [3:0]  m_lvl;
   logic        e_rd, e_wr, e_ck, e_rs;
   logic [23:0] e_addr;
   logic [7:0]  e_pa, e_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ctl_q.delete();
      bus_q.delete();
      // Synchroniser and pipe stages start at zero
      for (int k = 0; k < FILTER + 2; k++) ctl_q.push_back(4'h0);
      bus_q.push_back(40'h0);
      bus_q.push_back(40'h0);
      m_lvl  = 4'h0;
      e_rd   = 1'b0;
      e_wr   = 1'b0;
      e_ck   = 1'b0;
      e_rs   = 1'b0;
      e_addr = '0;
      e_pa   = '0;
      e_data = '0;
   endtask

   task automatic model_edge();
      logic [3:0]  ev;
      logic [3:0]  cur;
      logic [39:0] p2;
      logic        in_rst, rdf, wrr, wrf, ckr, rsr;
      // The value compared at this edge was sampled two edges ago
      for (int i = 0; i < 4; i++) begin
         ev[i] = 1'b1;
         for (int k = 0; k < FILTER; k++) begin
            cur = ctl_q[ctl_q.size() - 2 - k];
            if (cur[i] == m_lvl[i]) ev[i] = 1'b0;
         end
      end
      in_rst = !m_lvl[3];
      rdf = ev[0] &  m_lvl[0];
      wrr = ev[1] & !m_lvl[1];
      wrf = ev[1] &  m_lvl[1];
      ckr = ev[2] & !m_lvl[2];
      rsr = ev[3] & !m_lvl[3];
      p2  = bus_q[bus_q.size() - 2];
      e_rd = rdf & !in_rst;
      e_wr = wrr & !in_rst;
      e_ck = ckr & !in_rst;
      e_rs = rsr;
      if (!in_rst && (rdf || wrf || ckr)) begin
         e_addr = p2[39:16];
         e_pa   = p2[15:8];
      end
      if (!in_rst && wrr) e_data = p2[7:0];
      m_lvl = m_lvl ^ ev;
      ctl_q.push_back({bus_if.SNES_RESET_IN, bus_if.SNES_CPU_CLK_IN,
                       bus_if.SNES_WRITE_IN, bus_if.SNES_READ_IN});
      bus_q.push_back({bus_if.SNES_ADDR_IN, bus_if.SNES_PA_IN, bus_if.SNES_DATA_IN});
      while (ctl_q.size() > 32) void'(ctl_q.pop_front());
      while (bus_q.size() > 32) void'(bus_q.pop_front());
   endtask

   task automatic compare_all();
      check("rd_strobe",     32'(bus_if.SNES_rd_strobe),    32'(e_rd));
      check("wr_strobe",     32'(bus_if.SNES_wr_strobe),    32'(e_wr));
      check("cycle_start",   32'(bus_if.SNES_cycle_start),  32'(e_ck));
      check("reset_strobe",  32'(bus_if.SNES_reset_strobe), 32'(e_rs));
      check("snes_in_reset", 32'(bus_if.snes_in_reset),     32'(!m_lvl[3]));
      check("snes_addr",     32'(bus_if.SNES_ADDR),         32'(e_addr));
      check("snes_pa",       32'(bus_if.SNES_PA),           32'(e_pa));
      check("snes_data",     32'(bus_if.SNES_DATA),         32'(e_data));
   endtask

   // ---------------- driver ----------------
   // One clock: model and DUT see the same inputs at the edge; outputs are
   // compared 1 time unit later. Inputs are changed only after this returns.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      compare_all();
   endtask

   task automatic step_quiet(input string tag);
      step();
      check({tag, "_no_rd"}, 32'(bus_if.SNES_rd_strobe),   32'd0);
      check({tag, "_no_ck"}, 32'(bus_if.SNES_cycle_start), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n                  = 1'b0;
      bus_if.SNES_READ_IN    = 1'b1;
      bus_if.SNES_WRITE_IN   = 1'b1;
      bus_if.SNES_CPU_CLK_IN = 1'b0;
      bus_if.SNES_RESET_IN   = 1'b1;
      bus_if.SNES_ADDR_IN    = '0;
      bus_if.SNES_PA_IN      = '0;
      bus_if.SNES_DATA_IN    = '0;
      model_reset();

      // Power-up
      repeat (5) step();
      check("reset_in_reset", 32'(bus_if.snes_in_reset), 32'd1);
      rst_n = 1'b1;
      repeat (3) step();
      check("pwr_rs_early", 32'(bus_if.SNES_reset_strobe), 32'd0);
      step();
      check("pwr_rs_strobe", 32'(bus_if.SNES_reset_strobe), 32'd1);
      check("pwr_in_reset",  32'(bus_if.snes_in_reset),     32'd0);
      check("pwr_no_wr",     32'(bus_if.SNES_wr_strobe),    32'd0);
      step();
      check("pwr_rs_width",  32'(bus_if.SNES_reset_strobe), 32'd0);
      repeat (4) step();

      // Read
      bus_if.SNES_ADDR_IN = 24'h00FFEB;
      bus_if.SNES_READ_IN = 1'b0;
      repeat (3) step();
      step();
      check("rd_strobe_lat", 32'(bus_if.SNES_rd_strobe), 32'd1);
      check("rd_addr",       32'(bus_if.SNES_ADDR),      32'h00FFEB);
      repeat (2) step();
      bus_if.SNES_READ_IN = 1'b1;
      repeat (6) step();

      // Write
      bus_if.SNES_PA_IN    = 8'hFF;
      bus_if.SNES_DATA_IN  = 8'h85;
      bus_if.SNES_WRITE_IN = 1'b0;
      repeat (4) step();
      check("wrf_pa", 32'(bus_if.SNES_PA), 32'hFF);
      repeat (2) step();
      bus_if.SNES_WRITE_IN = 1'b1;
      repeat (3) step();
      check("wr_early", 32'(bus_if.SNES_wr_strobe), 32'd0);
      step();
      check("wr_strobe_lat", 32'(bus_if.SNES_wr_strobe), 32'd1);
      check("wr_data",       32'(bus_if.SNES_DATA),      32'h85);
      repeat (6) step();

      // Glitch on /RD
      bus_if.SNES_ADDR_IN = 24'h123456;
      bus_if.SNES_READ_IN = 1'b0;
      step();
      bus_if.SNES_READ_IN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("glitch_no_rd", 32'(bus_if.SNES_rd_strobe), 32'd0);
      end
      check("glitch_addr", 32'(bus_if.SNES_ADDR), 32'h00FFEB);

      // Activity while /RESET is low
      bus_if.SNES_RESET_IN = 1'b0;
      repeat (5) step();
      check("inrst_level", 32'(bus_if.snes_in_reset), 32'd1);
      bus_if.SNES_ADDR_IN = 24'hABCDEF;
      for (int i = 0; i < 3; i++) begin
         bus_if.SNES_CPU_CLK_IN = 1'b1;
         repeat (4) step_quiet("inrst");
         bus_if.SNES_CPU_CLK_IN = 1'b0;
         repeat (4) step_quiet("inrst");
      end
      bus_if.SNES_READ_IN = 1'b0;
      repeat (5) step_quiet("inrst");
      bus_if.SNES_READ_IN = 1'b1;
      repeat (5) step_quiet("inrst");
      check("inrst_addr_held", 32'(bus_if.SNES_ADDR), 32'h00FFEB);
      bus_if.SNES_RESET_IN = 1'b1;
      repeat (3) step();
      step();
      check("rel_rs_strobe", 32'(bus_if.SNES_reset_strobe), 32'd1);
      check("rel_in_reset",  32'(bus_if.snes_in_reset),     32'd0);
      repeat (4) step();
      bus_if.SNES_CPU_CLK_IN = 1'b1;
      repeat (3) step();
      step();
      check("rel_cycle_start", 32'(bus_if.SNES_cycle_start), 32'd1);
      check("rel_ck_addr",     32'(bus_if.SNES_ADDR),        32'hABCDEF);
      bus_if.SNES_CPU_CLK_IN = 1'b0;
      repeat (6) step();

      // Asynchronous abort while a write strobe is high
      bus_if.SNES_DATA_IN  = 8'h3C;
      bus_if.SNES_WRITE_IN = 1'b0;
      repeat (6) step();
      bus_if.SNES_WRITE_IN = 1'b1;
      repeat (4) step();
      check("abort_pre_wr", 32'(bus_if.SNES_wr_strobe), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("abort_wr_drop",  32'(bus_if.SNES_wr_strobe), 32'd0);
      check("abort_in_reset", 32'(bus_if.snes_in_reset),  32'd1);
      check("abort_addr",     32'(bus_if.SNES_ADDR),      32'd0);
      check("abort_data",     32'(bus_if.SNES_DATA),      32'd0);
      compare_all();
      repeat (3) step();
      rst_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0)  bus_if.SNES_READ_IN    = ~bus_if.SNES_READ_IN;
         if ($urandom_range(0, 3) == 0)  bus_if.SNES_WRITE_IN   = ~bus_if.SNES_WRITE_IN;
         if ($urandom_range(0, 2) == 0)  bus_if.SNES_CPU_CLK_IN = ~bus_if.SNES_CPU_CLK_IN;
         if ($urandom_range(0, 59) == 0) bus_if.SNES_RESET_IN   = ~bus_if.SNES_RESET_IN;
         bus_if.SNES_ADDR_IN = 24'($urandom);
         bus_if.SNES_PA_IN   = 8'($urandom);
         bus_if.SNES_DATA_IN = 8'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
